// File: rtl/id_operand_interlock.sv
// Decode-stage operand unit for the 5-stage MIPS pipeline.
// Holds the fetched instruction while the pipe is stalled. Resolves the rs and rt
// operands from the forwarding channels (channel 0 is the youngest) or from the regfile.
// Raises the load-use interlock and runs a stall watchdog.
// Optional feature macro: FWD_STATS_EN enables the stall and load-use statistics counters.
module id_operand_interlock #(
  parameter int DATA_W        = 32,
  parameter int REG_AW        = 5,
  parameter int NUM_FWD       = 3,
  parameter int TO_W          = 8,
  parameter int STALL_TIMEOUT = 200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      pipe_stall,
  input  logic                      inst_valid,
  input  logic [31:0]               inst_in,
  input  logic                      rs_used,
  input  logic                      rt_used,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD-1:0]        fwd_load,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  output logic [31:0]               inst_out,
  output logic                      inst_out_vld,
  output logic [DATA_W-1:0]         rs_value,
  output logic [DATA_W-1:0]         rt_value,
  output logic                      stallreq,
  output logic                      err_timeout,
  output logic [31:0]               stat_stalls,
  output logic [31:0]               stat_lduse
);

  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] value;
    logic              pend;
  } opnd_t;

  logic [0:0]        state;
  logic [31:0]       hold_reg;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_cnt_inc;
  logic              hold;
  logic [REG_AW-1:0] rs_addr, rt_addr;
  opnd_t             rs_r, rt_r;

  // Youngest matching channel wins. Register $0 never matches and always reads as zero.
  function automatic opnd_t resolve(
    input logic [REG_AW-1:0]         src,
    input logic [DATA_W-1:0]         rf,
    input logic [NUM_FWD-1:0]        we,
    input logic [NUM_FWD-1:0]        ld,
    input logic [NUM_FWD*REG_AW-1:0] wa,
    input logic [NUM_FWD*DATA_W-1:0] wd
  );
    opnd_t r;
    logic  found;
    r.value = rf;
    r.pend  = 1'b0;
    found   = 1'b0;
    if (src == '0) begin
      r.value = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && we[i] && (wa[i*REG_AW +: REG_AW] == src)) begin
          found   = 1'b1;
          r.value = wd[i*DATA_W +: DATA_W];
          r.pend  = ld[i];
        end
      end
    end
    return r;
  endfunction

  // Instruction select. A flush or reset kills the valid flag in the same cycle.
  always_comb begin
    inst_out     = (state == ST_HOLD) ? hold_reg : inst_in;
    inst_out_vld = ~rst & ~flush & ((state == ST_HOLD) | inst_valid);
  end

  assign rs_addr = inst_out[21 +: REG_AW];
  assign rt_addr = inst_out[16 +: REG_AW];

  // Operand resolution and the load-use interlock. Pure combinational logic, no added latency.
  always_comb begin
    rs_r     = resolve(rs_addr, rf_rdata1, fwd_we, fwd_load, fwd_waddr, fwd_wdata);
    rt_r     = resolve(rt_addr, rf_rdata2, fwd_we, fwd_load, fwd_waddr, fwd_wdata);
    rs_value = rs_r.value;
    rt_value = rt_r.value;
    stallreq = inst_out_vld & ((rs_used & rs_r.pend) | (rt_used & rt_r.pend));
  end

  assign hold = stallreq | pipe_stall;

  // PASS/HOLD state and the held instruction. A flush always returns to PASS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_PASS;
      hold_reg <= '0;
    end else begin
      case (state)
        ST_PASS: if (hold && inst_valid && !flush) begin
          state    <= ST_HOLD;
          hold_reg <= inst_in;
        end
        default: if (flush || !hold) state <= ST_PASS;
      endcase
    end
  end

  assign to_cnt_inc = (to_cnt == {TO_W{1'b1}}) ? to_cnt : to_cnt + 1'b1;

  // Watchdog on consecutive HOLD cycles. The error is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_HOLD && !flush) begin
        to_cnt <= to_cnt_inc;
        if (to_cnt_inc == TO_W'(STALL_TIMEOUT)) err_timeout <= 1'b1;
      end else begin
        to_cnt <= '0;
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] stalls_q, lduse_q;
  logic        stallreq_q;

  // Saturating counters: hold cycles with a live instruction, and rising edges of the interlock.
  always_ff @(posedge clk) begin
    if (rst) begin
      stalls_q   <= '0;
      lduse_q    <= '0;
      stallreq_q <= 1'b0;
    end else begin
      stallreq_q <= stallreq;
      if (hold && inst_out_vld && stalls_q != 32'hFFFF_FFFF) stalls_q <= stalls_q + 1'b1;
      if (stallreq && !stallreq_q && lduse_q != 32'hFFFF_FFFF) lduse_q <= lduse_q + 1'b1;
    end
  end

  assign stat_stalls = stalls_q;
  assign stat_lduse  = lduse_q;
`else
  assign stat_stalls = '0;
  assign stat_lduse  = '0;
`endif

endmodule
